// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary window decoder.
package unary_pkg;

    typedef enum logic {ST_SKIP, ST_ACC} udec_state_t;

    function automatic int unsigned win_len(input int unsigned bitw);
        return 32'd1 << bitw;
    endfunction

endpackage

// File: rtl/output_slot.sv
// One-entry valid/ready holding register; reports loads that find it full and unpopped.
module output_slot #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] data_out,
    output logic             drop
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             pop_eff;

    always_comb begin
        pop_eff = pop & full_q;
        drop    = load & full_q & ~pop;
        full_d  = full_q & ~pop_eff;
        data_d  = data_q;
        // A pop in the same cycle frees the slot for the incoming value.
        if (load && (!full_q || pop_eff)) begin
            full_d = 1'b1;
            data_d = data_in;
        end
        if (clr) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full     = full_q;
    assign data_out = data_q;

endmodule

// File: rtl/unary_window_decoder.sv
// Unary bitstream to binary count: skips start-up bits, then counts ones per 2**BITW window.
module unary_window_decoder
    import unary_pkg::*;
#(
    parameter int unsigned BITW = 4,
    parameter int unsigned SKIP = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_vld,
    input  logic            in_bit,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [BITW:0]   out_cnt,
    output logic            ovf
);

    localparam int unsigned SkipW = (SKIP == 0) ? 1 : $clog2(SKIP + 1);
    localparam int unsigned CntW  = BITW + 1;
    localparam udec_state_t StInit = (SKIP == 0) ? ST_ACC : ST_SKIP;
    localparam logic [SkipW-1:0] SkipLast = SkipW'((SKIP == 0) ? 0 : SKIP - 1);
    localparam logic [BITW-1:0]  WinLast  = BITW'(win_len(BITW) - 1);

    udec_state_t      state_q, state_d;
    logic [SkipW-1:0] skip_q, skip_d;
    logic [BITW-1:0]  win_q, win_d;
    logic [BITW-1:0]  ones_q, ones_d;
    logic             ovf_q, ovf_d;
    logic             done;
    logic [CntW-1:0]  result;
    logic             drop;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        win_d   = win_q;
        ones_d  = ones_q;
        done    = 1'b0;
        result  = {1'b0, ones_q} + CntW'(in_bit);
        if (clr) begin
            state_d = StInit;
            skip_d  = '0;
            win_d   = '0;
            ones_d  = '0;
        end else if (in_vld) begin
            unique case (state_q)
                ST_SKIP: begin
                    skip_d = skip_q + 1'b1;
                    if (skip_q == SkipLast) begin
                        state_d = ST_ACC;
                    end
                end
                ST_ACC: begin
                    win_d = win_q + 1'b1;
                    // Last bit of the window: ones_q never exceeds 2**BITW-1 here.
                    if (win_q == WinLast) begin
                        done   = 1'b1;
                        ones_d = '0;
                    end else begin
                        ones_d = ones_q + BITW'(in_bit);
                    end
                end
            endcase
        end
    end

    always_comb begin
        ovf_d = clr ? 1'b0 : (ovf_q | drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            skip_q  <= '0;
            win_q   <= '0;
            ones_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            win_q   <= win_d;
            ones_q  <= ones_d;
            ovf_q   <= ovf_d;
        end
    end

    output_slot #(
        .WIDTH (CntW)
    ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (done),
        .data_in  (result),
        .pop      (out_rdy),
        .full     (out_vld),
        .data_out (out_cnt),
        .drop     (drop)
    );

    assign ovf = ovf_q;

endmodule

// File: tb/tb_unary_window_decoder.sv
// Randomized and directed checks of two decoder instances (SKIP=2 and SKIP=0) against a window model.
module tb_unary_window_decoder;

    localparam int BITW = 4;
    localparam int WIN  = 16;

    logic clk = 1'b0;
    logic rst, clr, in_vld, in_bit, out_rdy;
    logic [1:0]    vld_o, ovf_o;
    logic [BITW:0] cnt_o [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance: valid bits seen, ones in current window, slot, overflow.
    int m_nv   [2];
    int m_ones [2];
    int m_cnt  [2];
    bit m_vld  [2];
    bit m_ovf  [2];

    always #5 clk = ~clk;

    unary_window_decoder #(.BITW(BITW), .SKIP(2)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .in_vld  (in_vld),
        .in_bit  (in_bit),
        .out_vld (vld_o[0]),
        .out_rdy (out_rdy),
        .out_cnt (cnt_o[0]),
        .ovf     (ovf_o[0])
    );

    unary_window_decoder #(.BITW(BITW), .SKIP(0)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .in_vld  (in_vld),
        .in_bit  (in_bit),
        .out_vld (vld_o[1]),
        .out_rdy (out_rdy),
        .out_cnt (cnt_o[1]),
        .ovf     (ovf_o[1])
    );

    function automatic int skip_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_nv[i]   = 0;
            m_ones[i] = 0;
            m_cnt[i]  = 0;
            m_vld[i]  = 1'b0;
            m_ovf[i]  = 1'b0;
        end
    endtask

    task automatic model_step(input bit v, input bit b, input bit r, input bit c);
        for (int i = 0; i < 2; i++) begin
            bit pop;
            bit complete;
            int res;
            if (c) begin
                m_nv[i]   = 0;
                m_ones[i] = 0;
                m_vld[i]  = 1'b0;
                m_ovf[i]  = 1'b0;
                continue;
            end
            pop      = m_vld[i] && r;
            complete = 1'b0;
            res      = 0;
            if (v) begin
                if (m_nv[i] >= skip_of(i)) begin
                    m_ones[i] += int'(b);
                    if ((m_nv[i] - skip_of(i)) % WIN == WIN - 1) begin
                        complete  = 1'b1;
                        res       = m_ones[i];
                        m_ones[i] = 0;
                    end
                end
                m_nv[i]++;
            end
            if (complete) begin
                if (!m_vld[i] || pop) begin
                    m_vld[i] = 1'b1;
                    m_cnt[i] = res;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end else if (pop) begin
                m_vld[i] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("vld%0d", i), 32'(vld_o[i]), 32'(m_vld[i]));
            check_eq($sformatf("ovf%0d", i), 32'(ovf_o[i]), 32'(m_ovf[i]));
            if (m_vld[i]) begin
                check_eq($sformatf("cnt%0d", i), 32'(cnt_o[i]), 32'(m_cnt[i]));
            end
        end
    endtask

    task automatic cycle(input bit v, input bit b, input bit r, input bit c);
        in_vld  = v;
        in_bit  = b;
        out_rdy = r;
        clr     = c;
        @(posedge clk);
        model_step(v, b, r, c);
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        in_vld  = 1'b0;
        in_bit  = 1'b0;
        out_rdy = 1'b0;
        clr     = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        check_eq("rst_cnt0", 32'(cnt_o[0]), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        int nv;
        int guard;
        bit v;
        bit b;
        rst = 1'b1;
        model_reset();
        apply_reset();

        // All-ones stream: first two bits skipped, full window gives 2**BITW.
        for (int k = 0; k < 18; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t1_vld", 32'(vld_o[0]), 32'd1);
        check_eq("t1_cnt", 32'(cnt_o[0]), 32'd16);

        // Alternating stream, always ready.
        for (int k = 0; k < 64; k++) cycle(1'b1, 1'((k + 1) % 2), 1'b1, 1'b0);
        check_eq("t2_cnt", 32'(cnt_o[0]), 32'd8);
        check_eq("t2_ovf", 32'(ovf_o[0]), 32'd0);

        // Sparse valids with junk on idle cycles; five ones in the window.
        nv = 0;
        guard = 0;
        while (nv < 16 && guard < 200) begin
            v = ($urandom_range(0, 9) < 4);
            b = v ? (nv < 5) : 1'($urandom);
            cycle(v, b, 1'b1, 1'b0);
            if (v) nv++;
            guard++;
        end
        check_eq("t3_nv", 32'(nv), 32'd16);
        check_eq("t3_vld", 32'(vld_o[0]), 32'd1);
        check_eq("t3_cnt", 32'(cnt_o[0]), 32'd5);

        // Stalled consumer across two completions, then pop coinciding with a third.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
        check_eq("t4_ovf", 32'(ovf_o[0]), 32'd1);
        check_eq("t4_vld", 32'(vld_o[0]), 32'd1);
        for (int k = 0; k < 15; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t4_cnt", 32'(cnt_o[0]), 32'd16);
        check_eq("t4_sticky", 32'(ovf_o[0]), 32'd1);

        // Clear mid-window, then an all-zero window.
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("t5_vld", 32'(vld_o[0]), 32'd0);
        check_eq("t5_ovf", 32'(ovf_o[0]), 32'd0);
        for (int k = 0; k < 18; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t5_vld2", 32'(vld_o[0]), 32'd1);
        check_eq("t5_cnt", 32'(cnt_o[0]), 32'd0);

        // Random soak, including rare clears.
        for (int k = 0; k < 2000; k++) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 199) == 0));
        end

        // Asynchronous reset between edges while holding a count and overflow.
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 45; k++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
        check_eq("t6_pre_ovf", 32'(ovf_o[0]), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("t6_vld%0d", i), 32'(vld_o[i]), 32'd0);
            check_eq($sformatf("t6_cnt%0d", i), 32'(cnt_o[i]), 32'd0);
            check_eq($sformatf("t6_ovf%0d", i), 32'(ovf_o[i]), 32'd0);
        end
        model_reset();
        #2;
        rst = 1'b0;

        // SKIP=0 counts from the first bit; SKIP=2 still mid-window.
        for (int k = 0; k < 16; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t6_s0_vld", 32'(vld_o[1]), 32'd1);
        check_eq("t6_s0_cnt", 32'(cnt_o[1]), 32'd16);
        check_eq("t6_s2_vld", 32'(vld_o[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
